// File: rtl/framebuffer_scanout.sv
// Double-buffered framebuffer scan-out: turns VGA scan positions into pixel-RAM
// reads and returns palette indices with sync/blank aligned, 2 Clk after pix_en.
module framebuffer_scanout #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int DW      = 8,
  parameter int SCALE2X = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          pix_en,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          blank_in,
  output logic          rd_en,
  output logic [19:0]   rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] pix_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          blank_out,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          front_buf,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned BUFSZ  = (SCALE2X != 0) ? (WIDTH / 2) * (HEIGHT / 2) : WIDTH * HEIGHT;
  localparam int unsigned STRIDE = (SCALE2X != 0) ? WIDTH / 2 : WIDTH;

  localparam logic [19:0] BUF_BASE = 20'(BUFSZ);
  localparam logic [19:0] STRIDE_W = 20'(STRIDE);
  localparam logic [9:0]  W_LAST   = 10'(WIDTH - 1);
  localparam logic [9:0]  H_LIM    = 10'(HEIGHT);

  logic [19:0] row_base;
  logic [19:0] col;
  logic [19:0] addr_next;
  logic        in_vblank;
  logic        stride_line;
  logic        line_end;
  logic        vblank_start;

  // Stage-1 sideband travelling alongside the RAM read.
  logic        s1_valid;
  logic        s1_hs;
  logic        s1_vs;
  logic        s1_blank;

  always_comb begin
    col          = (SCALE2X != 0) ? {11'd0, DrawX[9:1]} : {10'd0, DrawX};
    addr_next    = (front_buf ? BUF_BASE : 20'd0) + row_base + col;
    in_vblank    = (DrawY >= H_LIM);
    // In 2x mode a stored row spans two screen lines, so advance on odd lines only.
    stride_line  = (SCALE2X == 0) || DrawY[0];
    line_end     = blank_in && (DrawX == W_LAST) && !in_vblank && stride_line;
    vblank_start = (DrawX == 10'd0) && (DrawY == H_LIM);
  end

  // NOTE: all state uses non-blocking assignments and a synchronous reset, so
  // reset simply wins over pix_en in the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      row_base  <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      s1_valid  <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_blank  <= 1'b0;
      pix_out   <= '0;
      hs_out    <= 1'b0;
      vs_out    <= 1'b0;
      blank_out <= 1'b0;
      swap_ack  <= 1'b0;
      front_buf <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rd_en    <= 1'b0;
      swap_ack <= 1'b0;
      s1_valid <= pix_en;

      if (pix_en) begin
        rd_en    <= blank_in;
        if (blank_in) rd_addr <= addr_next;
        s1_hs    <= hs_in;
        s1_vs    <= vs_in;
        s1_blank <= blank_in;

        if (in_vblank)     row_base <= '0;
        else if (line_end) row_base <= row_base + STRIDE_W;

        // Flips happen only here, so a scanned frame never mixes buffers.
        if (vblank_start) begin
          frame_cnt <= frame_cnt + 8'd1;
          if (swap_req) begin
            front_buf <= ~front_buf;
            swap_ack  <= 1'b1;
          end
        end
      end

      if (s1_valid) begin
        pix_out   <= s1_blank ? rd_data : '0;
        hs_out    <= s1_hs;
        vs_out    <= s1_vs;
        blank_out <= s1_blank;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Randomized scoreboard bench for framebuffer_scanout: normal and 2x-scaled
// instances share one sparse scan; a behavioural model predicts every output.
module tb_framebuffer_scanout;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int DW = 8;

  typedef struct packed {
    logic          rd_en;
    logic [19:0]   addr;
    logic          ack;
    logic          front;
    logic [7:0]    fcnt;
    logic [DW-1:0] pix;
    logic          hs;
    logic          vs;
    logic          bl;
    logic          lit_v;
    logic [19:0]   lit_addr;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Reset, pix_en, hs_in, vs_in, blank_in, swap_req;
  logic [9:0]    DrawX, DrawY;
  logic          rd_en_w [2];
  logic [19:0]   rd_addr_w [2];
  logic [DW-1:0] rd_data_w [2];
  logic [DW-1:0] pix_w [2];
  logic          hs_w [2], vs_w [2], bl_w [2], ack_w [2], front_w [2];
  logic [7:0]    fcnt_w [2];

  framebuffer_scanout #(.WIDTH(W), .HEIGHT(H), .DW(DW), .SCALE2X(0)) u0 (
    .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]),
    .pix_out(pix_w[0]), .hs_out(hs_w[0]), .vs_out(vs_w[0]), .blank_out(bl_w[0]),
    .swap_req(swap_req), .swap_ack(ack_w[0]), .front_buf(front_w[0]), .frame_cnt(fcnt_w[0])
  );

  framebuffer_scanout #(.WIDTH(W), .HEIGHT(H), .DW(DW), .SCALE2X(1)) u1 (
    .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]),
    .pix_out(pix_w[1]), .hs_out(hs_w[1]), .vs_out(vs_w[1]), .blank_out(bl_w[1]),
    .swap_req(swap_req), .swap_ack(ack_w[1]), .front_buf(front_w[1]), .frame_cnt(fcnt_w[1])
  );

  always #5 Clk = ~Clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t q1 [2][$];
  exp_t q2 [2][$];

  // Reference model state
  int          lines_done [2];
  int          front_m [2];
  int          fcnt_m [2];
  logic [19:0] last_addr [2];
  bit          drop_on_ack  = 1'b1;
  bit          drop_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ram_word(input logic [19:0] a);
    logic [19:0] t;
    t = (a * 20'd13) ^ (a >> 7);
    return t[DW-1:0];
  endfunction

  function automatic int bufsz(input int m);
    return (m == 1) ? (W / 2) * (H / 2) : W * H;
  endfunction

  function automatic int stride(input int m);
    return (m == 1) ? W / 2 : W;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      lines_done[m] = 0;
      front_m[m]    = 0;
      fcnt_m[m]     = 0;
      last_addr[m]  = '0;
    end
    drop_pending = 1'b0;
  endtask

  // Expected result of one pix_en, from the addressing and flip rules directly.
  task automatic model_step(input int m, output exp_t e);
    int x, y, col;
    x   = int'(DrawX);
    y   = int'(DrawY);
    col = (m == 1) ? x / 2 : x;
    e   = '0;
    e.hs = hs_in;
    e.vs = vs_in;
    e.bl = blank_in;
    if (blank_in) begin
      e.rd_en      = 1'b1;
      last_addr[m] = 20'(front_m[m] * bufsz(m) + lines_done[m] * stride(m) + col);
    end
    e.addr = last_addr[m];
    e.pix  = blank_in ? ram_word(e.addr) : '0;
    if (m == 0 && x == 5 && y == 2 && front_m[0] == 0 && blank_in) begin
      e.lit_v = 1'b1; e.lit_addr = 20'd1285;
    end
    if (m == 1 && x == 9 && y == 3 && front_m[1] == 1 && blank_in) begin
      e.lit_v = 1'b1; e.lit_addr = 20'd77124;
    end
    if (y >= H) lines_done[m] = 0;
    else if (blank_in && x == W - 1 && (m == 0 || y % 2 == 1)) lines_done[m]++;
    if (x == 0 && y == H) begin
      fcnt_m[m] = (fcnt_m[m] + 1) % 256;
      if (swap_req) begin
        front_m[m] = 1 - front_m[m];
        e.ack      = 1'b1;
        if (drop_on_ack) drop_pending = 1'b1;
      end
    end
    e.front = front_m[m][0];
    e.fcnt  = 8'(fcnt_m[m]);
  endtask

  task automatic slot(input int x, input int y, input bit bl, input bit hs, input bit vs);
    exp_t e;
    @(posedge Clk); #1;
    if ($urandom_range(0, 1) == 1) begin
      pix_en = 1'b0;
      @(posedge Clk); #1;
    end
    if (drop_pending) begin
      swap_req     = 1'b0;
      drop_pending = 1'b0;
    end
    DrawX = 10'(x); DrawY = 10'(y);
    hs_in = hs; vs_in = vs; blank_in = bl;
    pix_en = 1'b1;
    for (int m = 0; m < 2; m++) begin
      model_step(m, e);
      q1[m].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      pix_en = 1'b0;
    end
  endtask

  // Reset with pix_en held high in the same edge; outputs must stay 0 afterwards.
  task automatic do_reset();
    @(posedge Clk); #1;
    Reset = 1'b1; pix_en = 1'b1; blank_in = 1'b1; DrawX = 10'd320;
    model_reset();
    @(posedge Clk); #1;
    pix_en = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    idle(3);
  endtask

  task automatic full_frame(input int req_y, input int drop_y, input int rst_y);
    for (int y = 0; y < H; y++) begin
      if (y == req_y)  swap_req = 1'b1;
      if (y == drop_y) swap_req = 1'b0;
      slot(0, y, 1, 1, 1);
      if (y == 2) slot(5, y, 1, 1, 1);
      if (y == 3) slot(9, y, 1, 1, 1);
      slot(int'($urandom_range(1, W - 2)), y, 1, 1, 1);
      if (y == rst_y) begin
        do_reset();
        slot(300, y, 1, 1, 1);
      end
      slot(W - 1, y, 1, 1, 1);
      slot(int'($urandom_range(W, 790)), y, 0, 1'($urandom_range(0, 1)), 1);
    end
    slot(0, H, 0, 1, 1);
    slot(200, H + 5, 0, 1, 1);
    slot(10, H + 10, 0, 1, 0);
    slot(10, H + 11, 0, 0, 0);
    slot(0, H + 40, 0, 1, 1);
    slot(300, H + 44, 0, 1, 1);
  endtask

  task automatic fast_frame();
    slot(3, H + 1, 0, 1, 1);
    slot(0, H, 0, 1, 1);
    slot(5, H + 20, 0, 0, 1);
  endtask

  // RAM: data for a strobed address is presented in the Clk after rd_en.
  initial begin
    forever begin
      @(negedge Clk);
      for (int m = 0; m < 2; m++)
        rd_data_w[m] = rd_en_w[m] ? ram_word(rd_addr_w[m]) : DW'($urandom);
    end
  end

  // Monitor: pops the scoreboard whenever a sampled pix_en has reached each stage.
  bit   s_pix   = 1'b0;
  bit   s_pix_d = 1'b0;
  bit   s_rst   = 1'b1;
  exp_t cur1 [2];
  exp_t cur2 [2];

  initial begin
    exp_t e;
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      for (int m = 0; m < 2; m++) begin
        if (s_rst) begin
          q1[m].delete();
          q2[m].delete();
          cur1[m] = '0;
          cur2[m] = '0;
        end else begin
          cur1[m].rd_en = 1'b0;
          cur1[m].ack   = 1'b0;
          if (s_pix) begin
            if (q1[m].size() == 0) begin
              failures++;
              $display("FAIL u%0d.stage1_underflow at %0t: got empty queue expected entry", m, $time);
            end else begin
              e = q1[m].pop_front();
              cur1[m] = e;
              q2[m].push_back(e);
              if (e.lit_v) check($sformatf("u%0d.directed_addr", m), 32'(rd_addr_w[m]), 32'(e.lit_addr));
            end
          end
          if (s_pix_d) begin
            if (q2[m].size() == 0) begin
              failures++;
              $display("FAIL u%0d.stage2_underflow at %0t: got empty queue expected entry", m, $time);
            end else begin
              cur2[m] = q2[m].pop_front();
            end
          end
        end
        check($sformatf("u%0d.rd_en", m),     32'(rd_en_w[m]),   32'(cur1[m].rd_en));
        check($sformatf("u%0d.rd_addr", m),   32'(rd_addr_w[m]), 32'(cur1[m].addr));
        check($sformatf("u%0d.swap_ack", m),  32'(ack_w[m]),     32'(cur1[m].ack));
        check($sformatf("u%0d.front_buf", m), 32'(front_w[m]),   32'(cur1[m].front));
        check($sformatf("u%0d.frame_cnt", m), 32'(fcnt_w[m]),    32'(cur1[m].fcnt));
        check($sformatf("u%0d.pix_out", m),   32'(pix_w[m]),     32'(cur2[m].pix));
        check($sformatf("u%0d.hs_out", m),    32'(hs_w[m]),      32'(cur2[m].hs));
        check($sformatf("u%0d.vs_out", m),    32'(vs_w[m]),      32'(cur2[m].vs));
        check($sformatf("u%0d.blank_out", m), 32'(bl_w[m]),      32'(cur2[m].bl));
      end
      s_pix_d = s_pix && !s_rst;
      s_pix   = pix_en;
      s_rst   = Reset;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; pix_en = 1'b0; DrawX = '0; DrawY = '0;
    hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0; swap_req = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    idle(2);

    full_frame(-1, -1, -1);     // plain frame from buffer 0
    full_frame(100, -1, -1);    // request mid-frame, flip at vblank start
    full_frame(200, 201, -1);   // request dropped before vblank: no flip

    drop_on_ack = 1'b0;         // held request flips once per vblank
    swap_req    = 1'b1;
    for (int i = 0; i < 10; i++) fast_frame();
    swap_req    = 1'b0;
    drop_on_ack = 1'b1;
    for (int i = 0; i < 250; i++) fast_frame();  // frame_cnt wraps 255 -> 0

    full_frame(-1, -1, 240);    // reset mid-frame, resync at next vblank
    full_frame(50, -1, -1);
    full_frame(int'($urandom_range(0, H - 1)), -1, -1);

    idle(5);
    for (int m = 0; m < 2; m++)
      check($sformatf("u%0d.queue_drain", m), 32'(q1[m].size() + q2[m].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 Parameter WIDTH, default 640, visible pixels per line.
REQ-002 Parameter HEIGHT, default 480, visible lines per frame.
REQ-003 Parameter DW, default 8, palette-index width of stored pixels.
REQ-004 Parameter SCALE2X, default 0; when 1, each stored pixel covers a 2x2 screen area and each buffer holds (WIDTH/2)*(HEIGHT/2) pixels.
REQ-005 Clk  in  1  system clock, 50 MHz; the block's only clock; reset is synchronous and active-high.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 pix_en  in  1  one-Clk strobe marking a new pixel slot; it may be asserted continuously or intermittently.
REQ-008 DrawX, DrawY  in  10 each  current scan position from the VGA timing generator, sampled on pix_en.
REQ-009 hs_in, vs_in  in  1 each  sync levels, sampled on pix_en.
REQ-010 blank_in  in  1  active-low blank, sampled on pix_en; 1 = visible.
REQ-011 rd_en  out  1  read strobe to the pixel RAM.
REQ-012 rd_addr  out  20  RAM word address.
REQ-013 rd_data  in  DW  RAM data, valid exactly 1 Clk after rd_en.
REQ-014 pix_out  out  DW  pixel to the palette mapper.
REQ-015 hs_out, vs_out, blank_out  out  1 each  sync and blank signals aligned with pix_out.
REQ-016 swap_req  in  1  level from the drawing engine requesting a buffer flip; held high until acknowledged.
REQ-017 swap_ack  out  1  one-Clk pulse confirming the flip.
REQ-018 front_buf  out  1  buffer currently being scanned; the writer owns the other buffer (~front_buf).
REQ-019 frame_cnt  out  8  frame counter.

Function
REQ-020 BUFSZ SHALL be WIDTH*HEIGHT, or (WIDTH/2)*(HEIGHT/2) when SCALE2X=1; rd_addr SHALL equal front_buf*BUFSZ + row_base + col.
REQ-021 col SHALL equal DrawX, or DrawX>>1 when SCALE2X=1; no multiplier SHALL be used: row_base is an accumulator register.
REQ-022 On a pix_en with blank_in=1, DrawX=WIDTH-1 and DrawY<HEIGHT, row_base SHALL add the line stride (WIDTH, or WIDTH/2 when SCALE2X=1 and DrawY[0]=1; otherwise it SHALL hold).
REQ-023 On a pix_en with DrawY>=HEIGHT, row_base SHALL clear to 0.
REQ-024 Stage 1: on a pix_en with blank_in=1, the block SHALL register rd_en=1 and rd_addr in the same edge; otherwise rd_en=0 and rd_addr holds. rd_en SHALL be high for at most one Clk per pix_en.
REQ-025 Stage 1 SHALL register hs_in, vs_in and blank_in with the address.
REQ-026 Stage 2 SHALL update pix_out, hs_out, vs_out and blank_out one Clk after stage 1, giving a fixed latency of 2 Clk from pix_en to outputs.
REQ-027 If the stage-1 blank is 0, pix_out SHALL be 0, ignoring rd_data.
REQ-028 Stage-2 outputs SHALL hold between updates.
REQ-029 Vblank start SHALL be a pix_en with DrawX=0 and DrawY=HEIGHT.
REQ-030 At vblank start, frame_cnt SHALL increment and wrap 255->0.
REQ-031 At vblank start with swap_req=1, front_buf SHALL toggle and swap_ack SHALL pulse in the same Clk.
REQ-032 A swap_req raised mid-frame SHALL wait for the next vblank start; a swap_req dropped before then SHALL cause no flip.
REQ-033 swap_ack SHALL pulse at most once per frame; a swap_req still high after the ack SHALL flip again at the next vblank only.
REQ-034 front_buf SHALL never change outside vblank start, so no frame is torn.

Reset
REQ-035 Reset SHALL set the following to 0: rd_en, rd_addr, row_base, pix_out, hs_out, vs_out, blank_out, swap_ack, front_buf and frame_cnt.
REQ-036 Reset SHALL take priority over pix_en in the same Clk.
REQ-037 Reset asserted mid-frame SHALL leave outputs at 0 until the first pix_en after release.
REQ-038 After reset release, row_base SHALL resynchronise at the next DrawY>=HEIGHT.

Verification
REQ-039 Continuous pix_en, DrawX=5, DrawY=2, blank=1, front=0, SCALE2X=0 -> rd_addr=1285 with rd_en the next Clk, and pix_out=rd_data 2 Clk after pix_en.
REQ-040 SCALE2X=1, front_buf=1, DrawX=9, DrawY=3 -> rd_addr=76800+320+4=77124.
REQ-041 swap_req raised at DrawY=100 and held -> no flip until DrawX=0, DrawY=480; then swap_ack is one pulse, front_buf goes 0->1 and frame_cnt goes +1.
REQ-042 blank=0 during the horizontal porch -> rd_en stays 0, pix_out=0, and hs_out/vs_out follow the inputs with a 2-Clk delay.
REQ-043 frame_cnt=255 at vblank start -> 0; swap_req pulsed and dropped at DrawY=200 -> no swap_ack and front_buf unchanged.
REQ-044 Reset at DrawY=240 mid-line -> all outputs 0; the next frame after release starts at rd_addr=front_buf*BUFSZ.
